// File: rtl/router_filereg_pkg.sv
// Shared definitions for the router file-register responder: field widths,
// command encodings and request/response message layouts.
package router_filereg_pkg;

  localparam int unsigned DefModuleAddressSize        = 11;
  localparam int unsigned DefCommandFieldSize         = 2;
  localparam int unsigned DefRegisterAddressFieldSize = 5;
  localparam int unsigned DefPayloadFieldSize         = 32;
  localparam int unsigned DefNumberOfRegisters        = 16;
  localparam int unsigned DefMessageSize              = DefCommandFieldSize +
                                                        DefRegisterAddressFieldSize +
                                                        DefPayloadFieldSize;
  localparam int unsigned DropCountWidth              = 16;

  // Request commands occupy 0/1; response commands reuse the otherwise illegal 2/3.
  typedef enum logic [DefCommandFieldSize-1:0] {
    CMD_WRITE     = 2'd0,
    CMD_READ      = 2'd1,
    RSP_READ      = 2'd2,
    RSP_WRITE_ACK = 2'd3
  } cmd_e;

  typedef struct packed {
    cmd_e                                   cmd;
    logic [DefRegisterAddressFieldSize-1:0] addr;
    logic [DefPayloadFieldSize-1:0]         payload;
  } msg_t;

  typedef struct packed {
    logic [DefModuleAddressSize-1:0] module_addr;
    logic [DefModuleAddressSize-1:0] src;
    msg_t                            msg;
  } req_t;

  typedef struct packed {
    logic [DefModuleAddressSize-1:0] dest;
    msg_t                            msg;
  } rsp_t;

endpackage

// File: rtl/router_filereg_bank.sv
// Configuration register bank: one write port, a combinational read mux that
// returns zero for unimplemented addresses, and a flattened export.
module router_filereg_bank
  import router_filereg_pkg::*;
#(
  parameter int unsigned AddrWidth = DefRegisterAddressFieldSize,
  parameter int unsigned DataWidth = DefPayloadFieldSize,
  parameter int unsigned NumRegs   = DefNumberOfRegisters
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_we,
  input  logic [AddrWidth-1:0]         i_waddr,
  input  logic [DataWidth-1:0]         i_wdata,
  input  logic [AddrWidth-1:0]         i_raddr,
  output logic [DataWidth-1:0]         o_rdata,
  output logic [NumRegs*DataWidth-1:0] o_flat
);

  logic [DataWidth-1:0] w_regs [NumRegs];

  // Address decode by equality, so out-of-range writes hit nothing.
  for (genvar g = 0; g < NumRegs; g++) begin : g_reg
    logic [DataWidth-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (i_we && (i_waddr == AddrWidth'(g))) begin
        r_q <= i_wdata;
      end
    end

    assign w_regs[g] = r_q;
    assign o_flat[g*DataWidth +: DataWidth] = r_q;
  end

  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (i_raddr == AddrWidth'(i)) begin
        o_rdata = w_regs[i];
      end
    end
  end

endmodule

// File: rtl/router_filereg_responder.sv
// File-register target: decodes NoC requests, updates the register bank and
// returns read responses. Define ROUTER_FILEREG_WRITE_ACK_EN to acknowledge writes.
module router_filereg_responder
  import router_filereg_pkg::*;
#(
  parameter int unsigned ModuleAddressSize        = DefModuleAddressSize,
  parameter int unsigned CommandFieldSize         = DefCommandFieldSize,
  parameter int unsigned RegisterAddressFieldSize = DefRegisterAddressFieldSize,
  parameter int unsigned PayloadFieldSize         = DefPayloadFieldSize,
  parameter int unsigned NumberOfRegisters        = DefNumberOfRegisters,
  parameter int unsigned MessageSize              = DefMessageSize,
  parameter int unsigned ModuleId                 = 0
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  input  logic [ModuleAddressSize-1:0]                  s_module,
  input  logic [ModuleAddressSize-1:0]                  s_src,
  input  logic [MessageSize-1:0]                        s_message,
  output logic                                          m_valid,
  input  logic                                          m_ready,
  output logic [ModuleAddressSize-1:0]                  m_dest,
  output logic [MessageSize-1:0]                        m_message,
  output logic [NumberOfRegisters*PayloadFieldSize-1:0] cfg_regs,
  output logic [DropCountWidth-1:0]                     drop_count
);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e                          r_state;
  logic                            r_s_ready;
  logic                            r_m_valid;
  logic [ModuleAddressSize-1:0]    r_m_dest;
  logic [MessageSize-1:0]          r_m_message;
  logic [DropCountWidth-1:0]       r_drop_count;

  logic [CommandFieldSize-1:0]         w_cmd;
  logic [RegisterAddressFieldSize-1:0] w_addr;
  logic [PayloadFieldSize-1:0]         w_payload;
  logic                                w_accept;
  logic                                w_match;
  logic                                w_is_write;
  logic                                w_is_read;
  logic                                w_respond;
  logic                                w_we;
  logic [PayloadFieldSize-1:0]         w_rdata;
  logic [CommandFieldSize-1:0]         w_rsp_cmd;
  logic [PayloadFieldSize-1:0]         w_rsp_data;

  assign w_cmd      = s_message[MessageSize-1 -: CommandFieldSize];
  assign w_addr     = s_message[PayloadFieldSize +: RegisterAddressFieldSize];
  assign w_payload  = s_message[PayloadFieldSize-1:0];

  assign w_accept   = s_valid && r_s_ready;
  assign w_match    = (s_module == ModuleAddressSize'(ModuleId));
  assign w_is_write = (w_cmd == CommandFieldSize'(CMD_WRITE));
  assign w_is_read  = (w_cmd == CommandFieldSize'(CMD_READ));
  assign w_we       = w_accept && w_match && w_is_write;

`ifdef ROUTER_FILEREG_WRITE_ACK_EN
  assign w_respond  = w_match && (w_is_read || w_is_write);
`else
  assign w_respond  = w_match && w_is_read;
`endif

  assign w_rsp_cmd  = w_is_read ? CommandFieldSize'(RSP_READ) : CommandFieldSize'(RSP_WRITE_ACK);
  assign w_rsp_data = w_is_read ? w_rdata : w_payload;

  router_filereg_bank #(
    .AddrWidth (RegisterAddressFieldSize),
    .DataWidth (PayloadFieldSize),
    .NumRegs   (NumberOfRegisters)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (w_addr),
    .i_wdata (w_payload),
    .i_raddr (w_addr),
    .o_rdata (w_rdata),
    .o_flat  (cfg_regs)
  );

  // s_ready resets low and rises on the first edge out of reset; it drops for
  // the whole response phase, giving one bubble per response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_s_ready   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_dest    <= '0;
      r_m_message <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_s_ready <= 1'b1;
          if (w_accept && w_respond) begin
            r_state     <= StResp;
            r_s_ready   <= 1'b0;
            r_m_valid   <= 1'b1;
            r_m_dest    <= s_src;
            r_m_message <= {w_rsp_cmd, w_addr, w_rsp_data};
          end
        end
        StResp: begin
          if (m_ready) begin
            r_state   <= StIdle;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count <= '0;
    end else if (w_accept && !w_match && (r_drop_count != '1)) begin
      r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign s_ready    = r_s_ready;
  assign m_valid    = r_m_valid;
  assign m_dest     = r_m_dest;
  assign m_message  = r_m_message;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_router_filereg_responder.sv
// Self-checking bench for router_filereg_responder: transaction-level model
// compared every cycle, plus hand-computed literal expectations.
module tb_router_filereg_responder;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [10:0]   s_module = '0;
  logic [10:0]   s_src = '0;
  logic [38:0]   s_message = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [10:0]   m_dest;
  logic [38:0]   m_message;
  logic [511:0]  cfg_regs;
  logic [15:0]   drop_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  router_filereg_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_module   (s_module),
    .s_src      (s_src),
    .s_message  (s_message),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_dest     (m_dest),
    .m_message  (m_message),
    .cfg_regs   (cfg_regs),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: register contents, drop count, pending responses.
  logic [31:0] mreg [16];
  int unsigned mdrop = 0;
  bit          started = 1'b0;
  logic [10:0] qdest [$];
  logic [38:0] qmsg  [$];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = '0;
    mdrop   = 0;
    started = 1'b0;
    qdest.delete();
    qmsg.delete();
  endtask

  task automatic model_request(input logic [10:0] modl, input logic [10:0] src,
                               input logic [38:0] msg);
    logic [1:0]  cmd;
    logic [4:0]  addr;
    logic [31:0] data;
    cmd  = msg[38:37];
    addr = msg[36:32];
    data = msg[31:0];
    if (modl != 11'd0) begin
      if (mdrop < 65535) mdrop++;
    end else if (cmd == 2'd0) begin
      if (addr < 16) mreg[addr[3:0]] = data;
`ifdef ROUTER_FILEREG_WRITE_ACK_EN
      qdest.push_back(src);
      qmsg.push_back({2'd3, addr, data});
`endif
    end else if (cmd == 2'd1) begin
      qdest.push_back(src);
      qmsg.push_back({2'd2, addr, (addr < 16) ? mreg[addr[3:0]] : 32'h0});
    end
  endtask

  initial model_reset();

  // Check current outputs, then advance the model past the coming rising edge.
  always @(negedge clk) begin
    logic [511:0] flat;
    if (!rst_n) begin
      model_reset();
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_dest", m_dest, 0);
      chk("rst_m_message", m_message, 0);
      chk("rst_cfg_regs", cfg_regs, 0);
      chk("rst_drop_count", drop_count, 0);
    end else begin
      flat = '0;
      for (int i = 0; i < 16; i++) flat[i*32 +: 32] = mreg[i];
      chk("cfg_regs", cfg_regs, flat);
      chk("drop_count", drop_count, mdrop);
      chk("s_ready", s_ready, started && (qmsg.size() == 0));
      chk("m_valid", m_valid, qmsg.size() != 0);
      if (qmsg.size() != 0) begin
        chk("m_dest", m_dest, qdest[0]);
        chk("m_message", m_message, qmsg[0]);
        if (m_ready) begin
          void'(qdest.pop_front());
          void'(qmsg.pop_front());
        end
      end else if (started && s_valid) begin
        model_request(s_module, s_src, s_message);
      end
      started = 1'b1;
    end
  end

  task automatic send(input logic [10:0] modl, input logic [10:0] src, input logic [1:0] cmd,
                      input logic [4:0] addr, input logic [31:0] data);
    bit acc;
    int n;
    s_valid   = 1'b1;
    s_module  = modl;
    s_src     = src;
    s_message = {cmd, addr, data};
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accepted", acc, 1);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [511:0] exp_flat;
  int c0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Write then read reg 3.
    send(11'd0, 11'h05, 2'd0, 5'd3, 32'hA5A5_0001);
    chk("w3_cfg", cfg_regs[127:96], 32'hA5A5_0001);
    idle(2);
    send(11'd0, 11'h12, 2'd1, 5'd3, 32'h0);
    chk("r3_valid", m_valid, 1);
    chk("r3_dest", m_dest, 11'h12);
    chk("r3_msg", m_message, {2'd2, 5'd3, 32'hA5A5_0001});
    idle(2);

    // Out-of-range accesses and an illegal command.
    send(11'd0, 11'h12, 2'd1, 5'd20, 32'h0);
    chk("r20_msg", m_message, {2'd2, 5'd20, 32'h0});
    idle(2);
    send(11'd0, 11'h12, 2'd0, 5'd20, 32'hDEAD_BEEF);
    idle(2);
    send(11'd0, 11'h12, 2'd3, 5'd5, 32'h1234_5678);
    idle(2);
    exp_flat = '0;
    exp_flat[127:96] = 32'hA5A5_0001;
    chk("oor_cfg", cfg_regs, exp_flat);
    chk("illegal_no_rsp", m_valid, 0);

    // Mismatched module address: consumed and counted only.
    send(11'd1, 11'h07, 2'd0, 5'd0, 32'h1111_1111);
    send(11'd1, 11'h07, 2'd1, 5'd3, 32'h0);
    send(11'd1, 11'h07, 2'd0, 5'd3, 32'h2222_2222);
    idle(2);
    chk("drop3_count", drop_count, 16'd3);
    chk("drop3_valid", m_valid, 0);
    chk("drop3_cfg", cfg_regs, exp_flat);

    // Back-pressured response; a second request waits for it.
    m_ready = 1'b0;
    send(11'd0, 11'h21, 2'd1, 5'd3, 32'h0);
    fork
      send(11'd0, 11'h22, 2'd1, 5'd4, 32'h0);
      begin
        repeat (5) begin
          chk("stall_s_ready", s_ready, 0);
          chk("stall_m_valid", m_valid, 1);
          chk("stall_m_msg", m_message, {2'd2, 5'd3, 32'hA5A5_0001});
          chk("stall_m_dest", m_dest, 11'h21);
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
    join
    chk("second_msg", m_message, {2'd2, 5'd4, 32'h0});
    chk("second_dest", m_dest, 11'h22);
    idle(3);

    // Back-to-back writes to every register.
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      send(11'd0, 11'h30, 2'd0, 5'(i), 32'hC0DE_0000 | i);
    end
`ifdef ROUTER_FILEREG_WRITE_ACK_EN
    chk("b2b_cycles", cyc - c0, 31);
`else
    chk("b2b_cycles", cyc - c0, 16);
`endif
    idle(3);
    for (int i = 0; i < 16; i++) begin
      chk("b2b_cfg", cfg_regs[i*32 +: 32], 32'hC0DE_0000 | i);
    end

    // Drop counter saturation.
    s_valid   = 1'b1;
    s_module  = 11'd1;
    s_message = {2'd1, 5'd0, 32'h0};
    repeat (65540) @(posedge clk);
    #1;
    idle(2);
    chk("drop_saturated", drop_count, 16'hFFFF);

    // Reset while a response is pending.
    m_ready = 1'b0;
    send(11'd0, 11'h33, 2'd1, 5'd3, 32'h0);
    chk("pre_rst_valid", m_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_cfg", cfg_regs, 0);
    chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_ready", s_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    idle(3);
    send(11'd0, 11'h34, 2'd1, 5'd3, 32'h0);
    chk("post_rst_msg", m_message, {2'd2, 5'd3, 32'h0});
    idle(3);

    chk("rsp_queue_empty", qmsg.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/router_filereg_responder.md
# router_filereg_responder

Register-file target for router configuration traffic. Accepts file-register access requests (module address, command, register address, payload) arriving from the network-on-chip ejection side, executes writes and reads against a local bank of 32-bit registers, and returns read responses toward the requester. It is the hardware endpoint for the request stream the router file-register request generator produces in simulation, and it exports the register bank to the router datapath as configuration.

## Interface
Parameters:
- ModuleAddressSize, 11, width of module address / source fields
- CommandFieldSize, 2, command field width
- RegisterAddressFieldSize, 5, register address field width
- PayloadFieldSize, 32, payload and register width
- NumberOfRegisters, 16, implemented registers (≤ 2^RegisterAddressFieldSize)
- MessageSize, 39, CommandFieldSize+RegisterAddressFieldSize+PayloadFieldSize
- ModuleId, 0, this instance's module address

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  request valid
- s_ready  out  1  request ready
- s_module  in  ModuleAddressSize  destination module address of request
- s_src  in  ModuleAddressSize  requester module address
- s_message  in  MessageSize  {command, register address, payload}, command in MSBs
- m_valid  out  1  response valid
- m_ready  in  1  response ready
- m_dest  out  ModuleAddressSize  response destination (= captured s_src)
- m_message  out  MessageSize  {response command, register address, data}
- cfg_regs  out  NumberOfRegisters*PayloadFieldSize  flattened register bank, register 0 in LSBs
- drop_count  out  16  requests discarded for module mismatch

## Operation
- Commands in: 0 WRITE, 1 READ; 2 and 3 are illegal. Response commands: 2 READ_RSP, 3 WRITE_ACK.
- Request accepted on s_valid && s_ready.
- s_module != ModuleId: request consumed, no effect, drop_count += 1, saturates at 0xFFFF.
- WRITE, address < NumberOfRegisters: register ← payload. Address out of range: ignored.
- READ: response {2, address, data}; data = register content, or 0 if address out of range.
- Illegal command: consumed, no effect, no response, not counted.
- FSM: IDLE (s_ready=1) → RESP on accepted READ (or WRITE with macro) → IDLE when m_valid && m_ready.
- RESP: s_ready=0, m_valid=1, m_dest/m_message stable until handshake.

## Timing
- Reset values: s_ready=0 during reset, 1 from first clock edge after deassertion; m_valid=0; m_dest=0; m_message=0; cfg_regs all 0; drop_count=0; FSM IDLE.
- Write: register updates at the accepting edge; visible on cfg_regs the following cycle. Back-to-back writes at one per cycle.
- Read: m_valid high the cycle after acceptance (1-cycle latency); read data sampled at the accepting edge, so a response reflects all earlier writes.
- Response leaves on m_ready handshake; s_ready returns high the next cycle (one bubble per response); maximum read throughput one per 2 cycles with m_ready held high.
- m_valid never drops without handshake; m_ready asserted with m_valid low has no effect.
- Reset mid-response: response discarded, registers cleared.

## Configuration
- ROUTER_FILEREG_WRITE_ACK_EN defined: every accepted WRITE to this module (in- or out-of-range) enters RESP and returns {3, address, written payload}, same timing as READ.
- Undefined: writes produce no response; FSM never leaves IDLE on WRITE.

## Structure
- Shared package router_filereg_pkg: field widths, command enum (CMD_WRITE, CMD_READ, RSP_READ, RSP_WRITE_ACK), request/response packed struct typedefs.
- One sub-module natural: router_filereg_bank (register array, write port, combinational read mux, flattened export); FSM, address match and counter in the top.

## Test plan
- Write 0xA5A5_0001 to reg 3, read reg 3 from src 0x12 → m_message {2,3,0xA5A5_0001}, m_dest 0x12, one cycle after acceptance; cfg_regs[127:96]=0xA5A5_0001.
- Read reg 20 → response data 0; write reg 20 → cfg_regs unchanged.
- s_module = ModuleId+1 three times → no response, no write, drop_count=3; force 0xFFFF preload path → stays 0xFFFF.
- Read with m_ready low for 5 cycles → m_valid, m_message stable; s_ready=0 throughout; second request waits and completes after.
- Back-to-back writes to regs 0..15 at one per cycle → all 16 values on cfg_regs; with ROUTER_FILEREG_WRITE_ACK_EN, 16 responses {3,addr,data} in order.
- Assert rst_n low while m_valid high → m_valid=0, cfg_regs=0, drop_count=0 immediately.
